// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the 16-bit RISC core: steps the datapath one state per clock.
// Outputs are a registered function of the state, and all of them read 0 while rst is high.
module mc_control_fsm #(
  parameter logic [3:0] OPC_HALT = 4'hF,
  parameter int         STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         opcode,
  input  logic               zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BNEq,
  output logic               MemRd,
  output logic               MemWr,
  output logic               IRd,
  output logic               IRWr,
  output logic               RegWrite,
  output logic               RegDest,
  output logic               MemToReg,
  output logic               SESF,
  output logic               JE,
  output logic               ALUSrcA,
  output logic [1:0]         R1Src,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [2:0]         ALUCtrl,
  output logic               halted,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_FETCH2, S_DECODE, S_EXEC, S_ALUWB, S_MADDR,
    S_MRD, S_MWB, S_MWR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam int CTRL_W = 23;

  state_t              state_q, state_d;
  logic [3:0]          opc_q, opc_d;
  logic [CTRL_W-1:0]   ctrl_q;

  // The branch decision (zero ^ BNEq) is resolved in the datapath's PC write enable.
  logic zero_unused;
  assign zero_unused = zero;

  function automatic logic [CTRL_W-1:0] ctrl_of(input state_t s, input logic [3:0] opc);
    logic pcw, pcwc, bneq, mrd, mwr, ird, irwr, rw, rdst, m2r, sesf, je, asa, hlt;
    logic [1:0] r1, asb, pcs;
    logic [2:0] alu;
    {pcw, pcwc, bneq, mrd, mwr, ird, irwr, rw, rdst, m2r, sesf, je, asa, hlt} = '0;
    r1  = 2'b00;
    asb = 2'b00;
    pcs = 2'b00;
    alu = 3'b000;
    case (s)
      S_FETCH: begin
        ird = 1'b1;
        pcw = 1'b1;
        asb = 2'b01;
      end
      S_FETCH2: irwr = 1'b1;
      S_DECODE: begin
        asb  = 2'b11;
        sesf = 1'b1;
      end
      S_EXEC, S_ALUWB: begin
        asa = 1'b1;
        rw  = (s == S_ALUWB);
        if (opc == 4'h7) begin
          asb  = 2'b10;
          sesf = 1'b1;
        end else if (opc == 4'h8) begin
          asb = 2'b10;
          alu = 3'b110;
        end else begin
          alu = opc[2:0];
        end
      end
      // Address operands stay on the ALU so ALUOut keeps the effective address.
      S_MADDR, S_MRD, S_MWR: begin
        asa  = 1'b1;
        asb  = 2'b10;
        sesf = 1'b1;
        mrd  = (s == S_MRD);
        mwr  = (s == S_MWR);
        r1   = (s == S_MWR) ? 2'b01 : 2'b00;
      end
      S_MWB: begin
        rw  = 1'b1;
        m2r = 1'b1;
      end
      S_BRANCH: begin
        asa  = 1'b1;
        alu  = 3'b001;
        pcwc = 1'b1;
        pcs  = 2'b01;
        bneq = ~opc[0];
      end
      S_JUMP: begin
        pcw  = 1'b1;
        pcs  = 2'b10;
        rw   = (opc == 4'hE);
        rdst = (opc == 4'hE);
        je   = (opc == 4'hE);
      end
      S_HALT: hlt = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, bneq, mrd, mwr, ird, irwr, rw, rdst, m2r, sesf, je, asa,
            r1, asb, pcs, alu, hlt};
  endfunction

  function automatic state_t decode_next(input logic [3:0] opc);
    if (opc == OPC_HALT)                      return S_HALT;
    else if (opc <= 4'h8)                     return S_EXEC;
    else if (opc == 4'h9 || opc == 4'hA)      return S_MADDR;
    else if (opc == 4'hB || opc == 4'hC)      return S_BRANCH;
    else if (opc == 4'hD || opc == 4'hE)      return S_JUMP;
    else                                      return S_HALT;
  endfunction

  always_comb begin
    opc_d   = (state_q == S_DECODE) ? opcode : opc_q;
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_FETCH2;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: state_d = decode_next(opcode);
      S_EXEC:   state_d = S_ALUWB;
      S_MADDR:  state_d = (opc_q == 4'h9) ? S_MRD : S_MWR;
      S_MRD:    state_d = S_MWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_of(S_FETCH, opc_q);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d, opc_d);
    end
    opc_q <= opc_d;
  end

  assign {PCWrite, PCWriteCond, BNEq, MemRd, MemWr, IRd, IRWr, RegWrite, RegDest,
          MemToReg, SESF, JE, ALUSrcA, R1Src, ALUSrcB, PCSrc, ALUCtrl, halted}
         = rst ? '0 : ctrl_q;
  assign state = rst ? S_FETCH : state_q;

endmodule
